// File: rtl/noc_traffic_injector.sv
// noc_traffic_injector: per-node synthetic traffic source for the mesh NoC.
// Generates single-flit packets with LFSR-driven random gaps and destinations
// chosen by PATTERN, and hands each flit to the local router via ReqDnStr/GntDnStr.
// Optional build macro: INJ_TIMESTAMP_EN replaces the module-ID field with the
// low bits of a free-running cycle counter captured when the request is raised.
module noc_traffic_injector #(
  parameter int DATA_WIDTH = 32,
  parameter int DIM        = 4,
  parameter int MID_W      = 6,
  parameter int MESH_X     = 5,
  parameter int MESH_Y     = 5,
  parameter int X_ID       = 0,
  parameter int Y_ID       = 0,
  parameter int MODULE_ID  = 0,
  parameter int PATTERN    = 1,
  parameter int FIXED_X    = 0,
  parameter int FIXED_Y    = 2,
  parameter int MAX_GAP    = 15,
  parameter int PKT_LIMIT  = 1023,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  GntDnStr,
  input  logic                  DnStrFull,
  output logic                  ReqDnStr,
  output logic [DATA_WIDTH-1:0] PacketOut,
  output logic [15:0]           pkt_count,
  output logic                  done
);

  localparam int ID_W = DATA_WIDTH - 4 * DIM - MID_W;

  typedef enum logic [2:0] {StIdle, StPrep, StSend, StWaitGrant, StDone} state_e;

  state_e                state_q;
  logic [15:0]           lfsr_q;
  logic [8:0]            gap_q;
  logic [8:0]            wait_q;
  logic [DIM-1:0]        dst_x_q;
  logic [DIM-1:0]        dst_y_q;
  logic [ID_W-1:0]       pkt_id_q;

  logic [8:0]            gap_next;
  logic [7:0]            rnd_x;
  logic [7:0]            rnd_y;
  logic [DIM-1:0]        dst_x_next;
  logic [DIM-1:0]        dst_y_next;
  logic [MID_W-1:0]      mid_val;
  logic [15:0]           cnt_inc;
  logic [DATA_WIDTH-1:0] flit;

  // Galois LFSR, right-shifting, free-running outside reset
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end
  end

`ifdef INJ_TIMESTAMP_EN
  logic [31:0] cycle_q;

  // Free-running cycle counter used as a timestamp in the module-ID field
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q <= '0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
    end
  end

  assign mid_val = MID_W'(cycle_q);
`else
  assign mid_val = MID_W'(MODULE_ID);
`endif

  // Gap, destination, flit and saturating count computed from current state
  always_comb begin
    // 9-bit modulus so MAX_GAP=255 does not collapse to mod 0
    gap_next = {1'b0, lfsr_q[7:0]} % 9'(MAX_GAP + 1);
    rnd_x    = lfsr_q[15:8] % 8'(MESH_X);
    rnd_y    = lfsr_q[7:0] % 8'(MESH_Y);
    // Never target ourselves under uniform random traffic
    if (rnd_x == 8'(X_ID) && rnd_y == 8'(Y_ID)) begin
      rnd_x = (rnd_x + 8'd1) % 8'(MESH_X);
    end
    case (PATTERN)
      0: begin
        dst_x_next = DIM'(FIXED_X);
        dst_y_next = DIM'(FIXED_Y);
      end
      2: begin
        dst_x_next = DIM'(Y_ID);
        dst_y_next = DIM'(X_ID);
      end
      3: begin
        dst_x_next = DIM'(MESH_X - 1 - X_ID);
        dst_y_next = DIM'(MESH_Y - 1 - Y_ID);
      end
      default: begin
        dst_x_next = DIM'(rnd_x);
        dst_y_next = DIM'(rnd_y);
      end
    endcase
    cnt_inc = (pkt_count == 16'hFFFF) ? pkt_count : pkt_count + 16'd1;
    flit    = {dst_x_q, dst_y_q, DIM'(X_ID), DIM'(Y_ID), pkt_id_q, mid_val};
  end

  // Injection FSM with registered handshake and flit outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      gap_q     <= '0;
      wait_q    <= '0;
      dst_x_q   <= '0;
      dst_y_q   <= '0;
      pkt_id_q  <= '0;
      ReqDnStr  <= 1'b0;
      PacketOut <= '0;
      pkt_count <= '0;
      done      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (enable && !done) begin
            gap_q   <= gap_next;
            wait_q  <= '0;
            state_q <= StPrep;
          end
        end
        StPrep: begin
          dst_x_q <= dst_x_next;
          dst_y_q <= dst_y_next;
          state_q <= StSend;
        end
        StSend: begin
          if (wait_q != gap_q) begin
            wait_q <= wait_q + 9'd1;
          end else if (!DnStrFull) begin
            ReqDnStr  <= 1'b1;
            PacketOut <= flit;
            state_q   <= StWaitGrant;
          end
        end
        StWaitGrant: begin
          if (GntDnStr) begin
            ReqDnStr  <= 1'b0;
            pkt_count <= cnt_inc;
            pkt_id_q  <= pkt_id_q + 1'b1;
            if (PKT_LIMIT != 0 && 32'(cnt_inc) == 32'(PKT_LIMIT)) begin
              done    <= 1'b1;
              state_q <= StDone;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        StDone: begin
          ReqDnStr <= 1'b0;
          done     <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_noc_traffic_injector.sv
// Testbench for noc_traffic_injector: directed steps plus a randomized run
// checked against a cycle-level behavioural model of injection timing.
module tb_noc_traffic_injector;

  localparam logic [15:0] Seed = 16'hACE1;
`ifdef INJ_TIMESTAMP_EN
  localparam bit TsEn = 1'b1;
`else
  localparam bit TsEn = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        en   [5];
  logic        gnt  [5];
  logic        full [5];
  logic        req  [5];
  logic [31:0] pkt  [5];
  logic [15:0] cnt  [5];
  logic        dn   [5];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [15:0] lhist[$];

  // u0: fixed pattern, zero gap, unlimited
  noc_traffic_injector #(.PATTERN(0), .MAX_GAP(0), .PKT_LIMIT(0), .LFSR_SEED(Seed)) u0 (
    .clk(clk), .reset(reset), .enable(en[0]), .GntDnStr(gnt[0]), .DnStrFull(full[0]),
    .ReqDnStr(req[0]), .PacketOut(pkt[0]), .pkt_count(cnt[0]), .done(dn[0]));
  // u1: uniform random at (2,2)
  noc_traffic_injector #(.PATTERN(1), .X_ID(2), .Y_ID(2), .MODULE_ID(42), .PKT_LIMIT(0),
                         .LFSR_SEED(Seed)) u1 (
    .clk(clk), .reset(reset), .enable(en[1]), .GntDnStr(gnt[1]), .DnStrFull(full[1]),
    .ReqDnStr(req[1]), .PacketOut(pkt[1]), .pkt_count(cnt[1]), .done(dn[1]));
  // u2: packet limit of 3
  noc_traffic_injector #(.PATTERN(0), .MAX_GAP(3), .PKT_LIMIT(3), .LFSR_SEED(Seed)) u2 (
    .clk(clk), .reset(reset), .enable(en[2]), .GntDnStr(gnt[2]), .DnStrFull(full[2]),
    .ReqDnStr(req[2]), .PacketOut(pkt[2]), .pkt_count(cnt[2]), .done(dn[2]));
  // u3: transpose at (1,3)
  noc_traffic_injector #(.PATTERN(2), .X_ID(1), .Y_ID(3), .LFSR_SEED(Seed)) u3 (
    .clk(clk), .reset(reset), .enable(en[3]), .GntDnStr(gnt[3]), .DnStrFull(full[3]),
    .ReqDnStr(req[3]), .PacketOut(pkt[3]), .pkt_count(cnt[3]), .done(dn[3]));
  // u4: bit-complement at (1,3)
  noc_traffic_injector #(.PATTERN(3), .X_ID(1), .Y_ID(3), .LFSR_SEED(Seed)) u4 (
    .clk(clk), .reset(reset), .enable(en[4]), .GntDnStr(gnt[4]), .DnStrFull(full[4]),
    .ReqDnStr(req[4]), .PacketOut(pkt[4]), .pkt_count(cnt[4]), .done(dn[4]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Module-ID field expected for a request raised on edge e after reset
  function automatic logic [5:0] mid_exp(input int e, input int modid);
    return TsEn ? 6'(e - 1) : 6'(modid);
  endfunction

  function automatic logic [31:0] mk_flit(input int dx, input int dy, input int sx, input int sy,
                                          input int pid, input logic [5:0] mid);
    return {4'(dx), 4'(dy), 4'(sx), 4'(sy), 10'(pid), mid};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock edge; outputs sampled 1 time unit later, LFSR history extended
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    lhist.push_back(lfsr_step(lhist[$]));
  endtask

  task automatic do_reset();
    for (int i = 0; i < 5; i++) begin
      en[i] = 1'b0; gnt[i] = 1'b0; full[i] = 1'b0;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0;
    lhist = {Seed};
  endtask

  initial begin
    int rise, start, grants, done_seen, req_after, prev;
    int t0, pid, cnt_m, gap, x, y, stalled;
    bit req_m, g_in, f_in;
    logic [31:0] exp_flit;

    reset = 1'b1;
    lhist = {Seed};
    do_reset();

    // Reset values
    chk("rst_req", 32'(req[0]), 0);
    chk("rst_pkt", pkt[0], 0);
    chk("rst_cnt", 32'(cnt[0]), 0);
    chk("rst_done", 32'(dn[0]), 0);

    // Fixed pattern, zero gap, grant one cycle after request
    en[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rise = -1;
      start = cyc;
      for (int i = 0; i < 20; i++) begin
        tick();
        if (req[0]) begin
          rise = cyc;
          break;
        end
      end
      chk("A_rise_edge", rise, start + 3);
      exp_flit = mk_flit(0, 2, 0, 0, k, mid_exp(rise, 0));
      chk("A_flit", pkt[0], exp_flit);
      gnt[0] = 1'b1;
      tick();
      gnt[0] = 1'b0;
      chk("A_req_drop", 32'(req[0]), 0);
      chk("A_count", 32'(cnt[0]), k + 1);
      chk("A_flit_stable", pkt[0], exp_flit);
    end

    // Router full at counter=gap holds the request back
    do_reset();
    en[0] = 1'b1;
    full[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("B_req_held", 32'(req[0]), 0);
    end
    full[0] = 1'b0;
    tick();
    chk("B_req_after_full", 32'(req[0]), 1);

    // Packet limit with a constantly asserted grant
    do_reset();
    en[2] = 1'b1;
    gnt[2] = 1'b1;
    grants = 0; done_seen = -1; req_after = 0; prev = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (prev != 0) grants++;
      if (dn[2] && done_seen < 0) begin
        done_seen = cyc;
        chk("C_grants_at_done", grants, 3);
      end
      if (done_seen >= 0 && req[2]) req_after++;
      prev = int'(req[2]);
    end
    chk("C_grants", grants, 3);
    chk("C_count", 32'(cnt[2]), 3);
    chk("C_done", 32'(dn[2]), 1);
    chk("C_req_after_done", req_after, 0);
    chk("C_idle_window", 32'(done_seen >= 0 && cyc - done_seen >= 100), 1);

    // Uniform random at (2,2), random grant and full, against the timing model
    do_reset();
    en[1] = 1'b1;
    t0 = 0; pid = 0; cnt_m = 0; req_m = 1'b0; stalled = 0;
    while (cnt_m < 1000 && cyc < 40000) begin
      g_in = 1'($urandom % 2);
      f_in = ($urandom % 4) == 0;
      gnt[1] = g_in;
      full[1] = f_in;
      tick();
      if (req_m) begin
        if (g_in) begin
          req_m = 1'b0;
          cnt_m++;
          pid = (pid + 1) % 1024;
          t0 = cyc;
          stalled = 0;
        end
      end else begin
        gap = int'(lhist[t0][7:0]) % 16;
        if (f_in) stalled = 1;
        if (cyc >= t0 + 3 + gap && !f_in) begin
          req_m = 1'b1;
          x = int'(lhist[t0 + 1][15:8]) % 5;
          y = int'(lhist[t0 + 1][7:0]) % 5;
          if (x == 2 && y == 2) x = 3;
          chk("D_flit", pkt[1], mk_flit(x, y, 2, 2, pid, mid_exp(cyc, 42)));
          chk("D_dst_range", 32'(pkt[1][31:28] < 4'd5 && pkt[1][27:24] < 4'd5), 1);
          chk("D_not_self", 32'(pkt[1][31:24] == 8'h22), 0);
          if (stalled == 0) chk("D_gap_bound", 32'(cyc - t0 - 3 <= 15), 1);
        end
      end
      chk("D_req", 32'(req[1]), 32'(req_m));
    end
    chk("D_packets", cnt_m, 1000);
    chk("D_count", 32'(cnt[1]), 1000);

    // Transpose and bit-complement at (1,3): both target (3,1)
    do_reset();
    en[3] = 1'b1;
    en[4] = 1'b1;
    for (int i = 0; i < 40; i++) tick();
    chk("E_p2_req", 32'(req[3]), 1);
    chk("E_p2_dst_src", 32'(pkt[3][31:16]), 32'h3113);
    chk("E_p3_req", 32'(req[4]), 1);
    chk("E_p3_dst_src", 32'(pkt[4][31:16]), 32'h3113);

    // Reset while waiting for a grant (grant asserted on the same edge)
    do_reset();
    en[0] = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("F_req_before", 32'(req[0]), 1);
    gnt[0] = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    gnt[0] = 1'b0;
    cyc = 0;
    lhist = {Seed};
    chk("F_req_reset", 32'(req[0]), 0);
    chk("F_cnt_reset", 32'(cnt[0]), 0);
    chk("F_pkt_reset", pkt[0], 0);
    for (int i = 0; i < 3; i++) tick();
    chk("F_req_again", 32'(req[0]), 1);
    chk("F_flit_pid0", pkt[0], mk_flit(0, 2, 0, 0, 0, mid_exp(3, 0)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/noc_traffic_injector.md
# noc_traffic_injector

Parametrised per-node traffic source for the mesh NoC simulator: generates single-flit packets under a selectable synthetic traffic pattern with LFSR-driven random inter-packet gaps, and hands each flit to the local router input port through a request/grant handshake. One instance sits at every mesh node. It supersedes the hard-coded per-node injectors with a single module configured by node coordinates, mesh size, pattern and packet budget.

## Interface
- DATA_WIDTH, 32, flit width.
- DIM, 4, bits per coordinate field.
- MID_W, 6, module-ID field width; ID_W = DATA_WIDTH-4*DIM-MID_W (10 at defaults), packet-ID width.
- MESH_X, 5 / MESH_Y, 5, mesh size.
- X_ID, 0 / Y_ID, 0, this node's coordinates.
- MODULE_ID, 0, value placed in module-ID field.
- PATTERN, 1, 0 fixed, 1 uniform random, 2 transpose, 3 bit-complement.
- FIXED_X, 0 / FIXED_Y, 2, destination for PATTERN 0.
- MAX_GAP, 15, maximum idle cycles between packets.
- PKT_LIMIT, 1023, packets to send; 0 = unlimited.
- LFSR_SEED, 16'hACE1, nonzero LFSR seed.
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  allows new packet generation.
- GntDnStr  in  1  grant from router.
- DnStrFull  in  1  router input FIFO full.
- ReqDnStr  out  1  request to router.
- PacketOut  out  DATA_WIDTH  flit {dst_x, dst_y, src_x, src_y, packet_id, module_id}, MSB first.
- pkt_count  out  16  packets granted since reset.
- done  out  1  PKT_LIMIT reached (sticky).

## Operation
- LFSR: 16-bit Galois, taps 16'hB400, shifts every cycle not in reset; loaded with LFSR_SEED on reset.
- IDLE: if enable=1 and not done, capture gap = lfsr[7:0] mod (MAX_GAP+1), clear wait counter, go PREP; else stay.
- PREP: compute destination, go SEND.
  - PATTERN 0: (FIXED_X, FIXED_Y).
  - PATTERN 1: x = lfsr[15:8] mod MESH_X, y = lfsr[7:0] mod MESH_Y; if equal to (X_ID,Y_ID), x := (x+1) mod MESH_X.
  - PATTERN 2: (Y_ID, X_ID). PATTERN 3: (MESH_X-1-X_ID, MESH_Y-1-Y_ID).
- SEND: if counter≠gap, counter+1. If counter=gap and DnStrFull=0: ReqDnStr<=1, PacketOut<=flit, go WAIT_GRANT. If counter=gap and DnStrFull=1: hold, counter frozen.
- WAIT_GRANT: on GntDnStr=1: ReqDnStr<=0, pkt_count+1, packet_id+1 (wraps mod 2^ID_W); go DONE if PKT_LIMIT≠0 and new pkt_count=PKT_LIMIT, else IDLE.
- DONE: done=1, ReqDnStr=0, stays until reset.
- enable is sampled only in IDLE; deassertion mid-packet lets the current packet complete.
- GntDnStr outside WAIT_GRANT is ignored. DnStrFull is not sampled in WAIT_GRANT.
- First packet has packet_id 0; src fields = (X_ID, Y_ID).
- pkt_count saturates at 16'hFFFF; packet_id keeps wrapping.

## Timing
- Reset values: ReqDnStr 0, PacketOut 0, pkt_count 0, done 0, packet_id 0, state IDLE.
- Reset wins over every other event; asserted in WAIT_GRANT, ReqDnStr is 0 after that edge.
- With enable=1, gap=g, not full: ReqDnStr rises at edge 3+g after entering IDLE.
- PacketOut changes only on the edge raising ReqDnStr; stable while ReqDnStr=1 and after.
- ReqDnStr falls on the edge sampling GntDnStr=1; the next request is at least 3 cycles later.
- Grant in the same cycle ReqDnStr rises is not possible (request registered); a grant held high is consumed once per packet.

## Configuration
- INJ_TIMESTAMP_EN defined: a 32-bit free-running cycle counter (cleared on reset) is kept; the module_id field carries counter[MID_W-1:0] captured on the edge raising ReqDnStr.
- Undefined: module_id field = MODULE_ID; no cycle counter is built.

## Test plan
- PATTERN 0, MAX_GAP=0, FIXED=(0,2), grant one cycle after request -> first PacketOut = 32'h0200_0000 with ReqDnStr high at edge 3, packet_ids 0,1,2 in sequence.
- DnStrFull held 1 for 10 cycles at counter=gap -> ReqDnStr stays 0, rises on the first edge after DnStrFull falls.
- PKT_LIMIT=3, constant grant -> exactly 3 grants, pkt_count=3, done=1, ReqDnStr stays 0 for 100 further cycles.
- PATTERN 1, node (2,2), 1000 packets -> every dst within 0..4 in each axis, none equals (2,2); gap always ≤ MAX_GAP.
- PATTERN 2 at (1,3) and PATTERN 3 at (1,3) -> dst (3,1) and (3,1) respectively.
- reset asserted in WAIT_GRANT -> next edge ReqDnStr=0, pkt_count=0, next packet_id 0; with INJ_TIMESTAMP_EN, module_id equals cycle-count low bits at request.
